// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one request/grant/rvalid memory port between an instruction
//   requester (read-only) and a data requester. Only one transaction is in
//   flight at a time. A fresh arbitration in IDLE is round-robin.
//
// Ports
//   clk_i, rst_i        : clock (rising edge) and asynchronous active-high reset
//   instr_req_i/addr_i  : instruction requester
//   instr_gnt_o/rvalid_o/rdata_o/err_o : instruction responses
//   data_req_i/addr_i/we_i/be_i/wdata_i : data requester
//   data_gnt_o/rvalid_o/rdata_o/err_o  : data responses
//   mem_req_o/addr_o/we_o/be_o/wdata_o : shared memory request channel
//   mem_gnt_i/rvalid_i/rdata_i/err_i   : shared memory response channel
//   proto_err_o         : sticky, rvalid seen while nothing was outstanding
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [AW-1:0] instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [DW-1:0] instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i,
  output logic          proto_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t state_reg;
  logic   owner_data_reg;  // 1: data requester owns the port, 0: instr
  logic   prio_data_reg;   // 1: data wins the next tie, 0: instr wins
  logic   proto_err_reg;

  logic   sel_data;
  logic   owner_data;
  logic   issue_req;
  logic   handshake;
  logic   rsp;

  always_comb begin
    // Tie-break only matters when both request; otherwise the lone requester wins.
    sel_data   = data_req_i && (!instr_req_i || prio_data_reg);
    // Once a request is pending the latched owner is final until granted.
    owner_data = (state_reg == IDLE) ? sel_data : owner_data_reg;
    // Outputs are held at zero for the whole time reset is asserted.
    issue_req  = !rst_i && (((state_reg == IDLE) && (instr_req_i || data_req_i)) ||
                            (state_reg == WAIT_GNT));
    handshake  = issue_req && mem_gnt_i;
    rsp        = !rst_i && (state_reg == WAIT_RVALID) && mem_rvalid_i;
  end

  assign mem_req_o   = issue_req;
  assign mem_addr_o  = !issue_req ? '0 : (owner_data ? data_addr_i : instr_addr_i);
  assign mem_we_o    = issue_req && owner_data && data_we_i;
  // Instruction fetches read the full word.
  assign mem_be_o    = !issue_req ? 4'b0000 : (owner_data ? data_be_i : 4'b1111);
  assign mem_wdata_o = (issue_req && owner_data) ? data_wdata_i : '0;

  assign instr_gnt_o = handshake && !owner_data;
  assign data_gnt_o  = handshake && owner_data;

  assign instr_rvalid_o = rsp && !owner_data_reg;
  assign instr_rdata_o  = (rsp && !owner_data_reg) ? mem_rdata_i : '0;
  assign instr_err_o    = rsp && !owner_data_reg && mem_err_i;
  assign data_rvalid_o  = rsp && owner_data_reg;
  assign data_rdata_o   = (rsp && owner_data_reg) ? mem_rdata_i : '0;
  assign data_err_o     = rsp && owner_data_reg && mem_err_i;

  assign proto_err_o = proto_err_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      owner_data_reg <= 1'b0;
      prio_data_reg  <= 1'b0;
      proto_err_reg  <= 1'b0;
    end else begin
      // Any rvalid with nothing outstanding is dropped and flagged forever.
      if (mem_rvalid_i && (state_reg != WAIT_RVALID))
        proto_err_reg <= 1'b1;

      if (handshake)
        prio_data_reg <= !owner_data;

      case (state_reg)
        IDLE: begin
          if (issue_req) begin
            owner_data_reg <= owner_data;
            state_reg      <= mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (mem_gnt_i)
            state_reg <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (mem_rvalid_i)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i;
  logic [AW-1:0] data_addr_i;
  logic [3:0]    data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [DW-1:0] mem_rdata_i;
  logic          proto_err_o;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          who;   // 1: data, 0: instr
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Responses are compared against the scoreboard at the falling edge.
  always @(negedge clk_i) begin
    if (instr_rvalid_o || data_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check_value("rsp_who", {data_rvalid_o, instr_rvalid_o}, e.who ? 2'b10 : 2'b01);
        check_value("rsp_rdata", e.who ? data_rdata_o : instr_rdata_o, e.rdata);
        check_value("rsp_err", e.who ? data_err_o : instr_err_o, e.err);
        check_value("rsp_other_zero",
                    e.who ? {instr_rdata_o, instr_err_o} : {data_rdata_o, data_err_o}, 0);
        $display("rsp who=%0d rdata=0x%0h err=%0d", e.who,
                 e.who ? data_rdata_o : instr_rdata_o, e.who ? data_err_o : instr_err_o);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_addr_i = '0; data_we_i = 0; data_be_i = 0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
  endtask

  task automatic pulse_reset();
    rst_i = 1;
    step(); step();
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    // Requests during reset must not reach the memory port.
    instr_req_i = 1; instr_addr_i = 32'h44; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    step(); sample();
    check_value("rst_mem_req", mem_req_o, 0);
    check_value("rst_mem_addr", mem_addr_o, 0);
    check_value("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
    check_value("rst_proto_err", proto_err_o, 0);
    check_value("rst_rdata", {instr_rdata_o, data_rdata_o}, 0);
    idle_inputs();
    step();
    rst_i = 0;

    // Single instruction read, grant in the request cycle, rvalid next.
    step();
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    sample();
    check_value("t1_mem_req", mem_req_o, 1);
    check_value("t1_mem_addr", mem_addr_o, 32'h100);
    check_value("t1_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    check_value("t1_we", mem_we_o, 0);
    exp_q.push_back('{who: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    $display("txn instr read addr=0x100");
    step();
    instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    sample();
    check_value("t1_rvalid", instr_rvalid_o, 1);
    check_value("t1_data_side", {data_rvalid_o, data_rdata_o, data_err_o}, 0);
    check_value("t1_no_req_in_wait", mem_req_o, 0);
    step();
    idle_inputs();
    sample();
    check_value("t1_rvalid_drop", instr_rvalid_o, 0);

    // Both requesting from reset: grants alternate instr, data, instr.
    pulse_reset();
    instr_req_i = 1; instr_addr_i = 32'h10;
    data_req_i = 1; data_addr_i = 32'h20;
    for (int k = 0; k < 3; k++) begin
      logic exp_data;
      exp_data = (k % 2) == 1;
      mem_gnt_i = 1; mem_rvalid_i = 0;
      sample();
      check_value("t2_gnt", {instr_gnt_o, data_gnt_o}, exp_data ? 2'b01 : 2'b10);
      check_value("t2_addr", mem_addr_o, exp_data ? 32'h20 : 32'h10);
      exp_q.push_back('{who: exp_data, rdata: 32'hA000 + k, err: 1'b0});
      $display("txn rr %0d owner=%s", k, exp_data ? "data" : "instr");
      step();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA000 + k;
      sample();
      check_value("t2_no_req_in_wait", mem_req_o, 0);
      step();
    end
    idle_inputs();
    step();

    // Data write held off by missing grant while instr starts requesting.
    pulse_reset();
    data_req_i = 1; data_addr_i = 32'h200; data_we_i = 1; data_be_i = 4'hC; data_wdata_i = 32'h55AA;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) instr_req_i = 1;
      instr_addr_i = 32'h999;
      sample();
      check_value("t3_addr_hold", mem_addr_o, 32'h200);
      check_value("t3_we", mem_we_o, 1);
      check_value("t3_req", mem_req_o, 1);
      check_value("t3_instr_gnt", instr_gnt_o, 0);
      step();
    end
    mem_gnt_i = 1;
    sample();
    check_value("t3_gnt", {instr_gnt_o, data_gnt_o}, 2'b01);
    check_value("t3_addr_at_gnt", mem_addr_o, 32'h200);
    check_value("t3_be_wdata", {mem_be_o, mem_wdata_o}, {4'hC, 32'h55AA});
    exp_q.push_back('{who: 1'b1, rdata: 32'h1234, err: 1'b0});
    $display("txn data write addr=0x200");
    step();
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
    step();
    idle_inputs();

    // Data read answered with an error.
    data_req_i = 1; data_addr_i = 32'h300; mem_gnt_i = 1;
    sample();
    check_value("t4_gnt", data_gnt_o, 1);
    exp_q.push_back('{who: 1'b1, rdata: 32'hBAD, err: 1'b1});
    $display("txn data read err addr=0x300");
    step();
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD; mem_err_i = 1;
    sample();
    check_value("t4_err", {data_err_o, instr_err_o}, 2'b10);
    step();
    idle_inputs();
    sample();
    check_value("t4_err_one_cycle", data_err_o, 0);
    check_value("t4_proto_clean", proto_err_o, 0);

    // Reset in WAIT_RVALID, then a stray rvalid.
    step();
    instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1;
    $display("txn instr read abandoned by reset");
    step();
    idle_inputs();
    pulse_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
    sample();
    check_value("t5_no_fwd", {instr_rvalid_o, data_rvalid_o}, 0);
    check_value("t5_no_fwd_rdata", instr_rdata_o, 0);
    step();
    mem_rvalid_i = 0;
    sample();
    check_value("t5_proto_err", proto_err_o, 1);
    step(); step();
    sample();
    check_value("t5_proto_sticky", proto_err_o, 1);
    rst_i = 1;
    sample();
    check_value("t5_proto_cleared", proto_err_o, 0);
    step();
    rst_i = 0;
    step();

    check_value("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, 32, address width.
REQ-002 SHALL have parameter DW, 32, data width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports instr_req_i in 1, instr_addr_i in AW: instruction requester (read-only).
REQ-006 SHALL have ports instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out DW, instr_err_o out 1.
REQ-007 SHALL have ports data_req_i in 1, data_addr_i in AW, data_we_i in 1, data_be_i in 4, data_wdata_i in DW: data requester.
REQ-008 SHALL have ports data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out DW, data_err_o out 1.
REQ-009 SHALL have ports mem_req_o out 1, mem_addr_o out AW, mem_we_o out 1, mem_be_o out 4, mem_wdata_o out DW: shared memory port.
REQ-010 SHALL have ports mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in DW, mem_err_i in 1.
REQ-011 SHALL have port proto_err_o  out  1  sticky flag: unexpected mem_rvalid_i.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID; at most one transaction outstanding.
REQ-013 SHALL, in IDLE with any request, select an owner combinationally and assert mem_req_o with the owner's address/we/be/wdata in the same cycle.
REQ-014 SHALL arbitrate round-robin: when both requesters request in IDLE, the one not granted last wins; priority pointer resets to favour instr.
REQ-015 SHALL update the priority pointer only on a cycle where mem_gnt_i and mem_req_o are both high.
REQ-016 SHALL latch the owner when a request cycle ends without mem_gnt_i and enter WAIT_GNT; the owner is then not changed until gnt.
REQ-017 SHALL, in WAIT_GNT, drive mem_* from the latched owner only; the other requester's req is ignored.
REQ-018 SHALL forward mem_gnt_i combinationally to the owner's gnt output only; the non-owner gnt is 0.
REQ-019 SHALL enter WAIT_RVALID on the cycle mem_req_o and mem_gnt_i are both high, recording the owner; mem_req_o is 0 in WAIT_RVALID.
REQ-020 SHALL, in WAIT_RVALID with mem_rvalid_i=1, drive owner's rvalid=1, rdata=mem_rdata_i, err=mem_err_i combinationally, then return to IDLE.
REQ-021 SHALL require mem_rvalid_i no earlier than the cycle after gnt; no back-to-back issue: next request issues at earliest the cycle after rvalid.
REQ-022 SHALL drive rdata outputs to 0 and rvalid/err to 0 for any requester not receiving a response.
REQ-023 SHALL pass write transactions unchanged; rvalid still terminates writes.
REQ-024 SHALL set proto_err_o when mem_rvalid_i=1 outside WAIT_RVALID; such rvalid is not forwarded; the flag is cleared only by reset.
REQ-025 SHALL tolerate a requester dropping req in IDLE before being selected (no transaction issued).
REQ-026 SHALL keep minimum latency request-to-rvalid as 2 cycles (gnt cycle 0, rvalid cycle 1).

Reset
REQ-027 SHALL, while rst_i=1, force state IDLE, priority pointer to instr, proto_err_o=0, all outputs 0.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation; a later stray mem_rvalid_i sets proto_err_o.

Verification
REQ-029 SHALL test: instr_req=1, addr=0x100, mem_gnt same cycle, rvalid next cycle rdata=0xDEADBEEF -> instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data outputs 0.
REQ-030 SHALL test: both req simultaneously from reset, gnt immediate, each rvalid 1 cycle later, both held -> grants alternate instr, data, instr.
REQ-031 SHALL test: data req addr=0x200 we=1, gnt withheld 3 cycles while instr_req rises -> mem_addr_o stays 0x200, instr_gnt_o=0 throughout.
REQ-032 SHALL test: data read with mem_err_i=1 at rvalid -> data_err_o=1 for one cycle, instr_err_o=0.
REQ-033 SHALL test: rst_i pulsed in WAIT_RVALID, then mem_rvalid_i=1 -> no rvalid forwarded, proto_err_o=1 until next reset.
